// File: rtl/hazard_stall_if.sv
// Bundle of hazard inputs from the ID/EX stages and the stall/flush controls
// returned to the pipeline latches. The unit uses the slave side.
interface hazard_stall_if #(
  parameter int CNT_W = 16
);
  logic             IDEX_MemRead;
  logic [3:0]       IDEX_rd;
  logic [3:0]       IFID_rs;
  logic [3:0]       IFID_rt;
  logic             IFID_uses_rs;
  logic             IFID_uses_rt;
  logic             branch_taken;
  logic             halt_in;
  logic             mem_busy;
  logic             pc_wen;
  logic             ifid_wen;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             stall_en;
  logic             halted;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output IDEX_MemRead, IDEX_rd, IFID_rs, IFID_rt, IFID_uses_rs, IFID_uses_rt,
           branch_taken, halt_in, mem_busy,
    input  pc_wen, ifid_wen, ifid_flush, idex_bubble, stall_en, halted, stall_count
  );

  modport slave (
    input  IDEX_MemRead, IDEX_rd, IFID_rs, IFID_rt, IFID_uses_rs, IFID_uses_rt,
           branch_taken, halt_in, mem_busy,
    output pc_wen, ifid_wen, ifid_flush, idex_bubble, stall_en, halted, stall_count
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard/stall controller: load-use interlock, branch squash,
// memory-busy freeze, HLT drain and a saturating stall-cycle counter.
module hazard_stall_unit #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  hazard_stall_if.slave  bus
);

  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t           state, state_eff, next_state;
  logic [DW-1:0]    drain_cnt, drain_next;
  logic [CNT_W-1:0] stall_cnt;
  logic             load_use, count_inc;
  logic             pc_wen, ifid_wen, ifid_flush, idex_bubble, stall_en;

  // Outputs decode as RUN while reset is held, whatever the register holds.
  assign state_eff = rst_n ? state : RUN;

  always_comb begin
    load_use = bus.IDEX_MemRead && (bus.IDEX_rd != 4'd0) &&
               ((bus.IFID_uses_rs && (bus.IFID_rs == bus.IDEX_rd)) ||
                (bus.IFID_uses_rt && (bus.IFID_rt == bus.IDEX_rd)));
  end

  always_comb begin
    pc_wen      = 1'b1;
    ifid_wen    = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    stall_en    = 1'b0;
    next_state  = state_eff;
    drain_next  = drain_cnt;
    case (state_eff)
      RUN: begin
        if (bus.mem_busy) begin
          pc_wen   = 1'b0;
          ifid_wen = 1'b0;
          stall_en = 1'b1;
        end else if (load_use) begin
          pc_wen      = 1'b0;
          ifid_wen    = 1'b0;
          idex_bubble = 1'b1;
        end else if (bus.halt_in) begin
          pc_wen     = 1'b0;
          ifid_flush = 1'b1;
          drain_next = DW'(DRAIN_CYCLES);
          next_state = DRAIN;
        end else if (bus.branch_taken) begin
          ifid_flush = 1'b1;
        end
      end
      DRAIN: begin
        pc_wen = 1'b0;
        if (bus.mem_busy) begin
          ifid_wen = 1'b0;
          stall_en = 1'b1;
        end else begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          drain_next  = drain_cnt - DW'(1);
          // A zero count only arises with DRAIN_CYCLES=0; treat it as done.
          if (drain_cnt <= DW'(1)) next_state = HALTED;
        end
      end
      default: begin
        pc_wen   = 1'b0;
        ifid_wen = 1'b0;
        stall_en = 1'b1;
      end
    endcase
    count_inc = (state_eff != HALTED) && (!pc_wen || stall_en || idex_bubble);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      drain_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= next_state;
      drain_cnt <= drain_next;
      if (count_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign bus.pc_wen      = pc_wen;
  assign bus.ifid_wen    = ifid_wen;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_bubble = idex_bubble;
  assign bus.stall_en    = stall_en;
  assign bus.halted      = (state == HALTED);
  assign bus.stall_count = stall_cnt;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit; comb outputs are packed as
// {pc_wen, ifid_wen, ifid_flush, idex_bubble, stall_en}.
module tb_hazard_stall_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errCount = 0;
  int   checkCount = 0;

  hazard_stall_if #(.CNT_W(16)) bus ();

  hazard_stall_unit #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkComb(input string tag, input logic [4:0] expected);
    #1;
    checkOutput(tag, 32'({bus.pc_wen, bus.ifid_wen, bus.ifid_flush,
                          bus.idex_bubble, bus.stall_en}), 32'(expected));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic mem_read, input logic [3:0] rd,
                               input logic [3:0] rs, input logic [3:0] rt,
                               input logic use_rs, input logic use_rt,
                               input logic br, input logic hlt, input logic busy);
    bus.IDEX_MemRead = mem_read;
    bus.IDEX_rd      = rd;
    bus.IFID_rs      = rs;
    bus.IFID_rt      = rt;
    bus.IFID_uses_rs = use_rs;
    bus.IFID_uses_rt = use_rt;
    bus.branch_taken = br;
    bus.halt_in      = hlt;
    bus.mem_busy     = busy;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset held for two edges with mem_busy high
    applyIdle();
    bus.mem_busy = 1'b1;
    #1;
    checkComb("reset_comb_freeze", 5'b00001);
    tick();
    tick();
    rst_n = 1'b1;
    bus.mem_busy = 1'b0;
    checkComb("reset_comb_run", 5'b11000);
    checkOutput("reset_count", 32'(bus.stall_count), 32'd0);
    checkOutput("reset_halted", 32'(bus.halted), 32'd0);

    // Load-use on rs
    applyStimulus(1'b1, 4'd5, 4'd5, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkComb("lu_rs_comb", 5'b00010);
    tick();
    applyIdle();
    checkComb("lu_rs_after", 5'b11000);
    checkOutput("lu_rs_count", 32'(bus.stall_count), 32'd1);

    // Async reset glitch between edges must not clear anything
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    checkOutput("glitch_count", 32'(bus.stall_count), 32'd1);

    // Register 0 never hazards
    applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkComb("lu_r0_comb", 5'b11000);
    tick();
    checkOutput("lu_r0_count", 32'(bus.stall_count), 32'd1);

    // rt match without uses_rt is no hazard; with uses_rt it is
    applyStimulus(1'b1, 4'd7, 4'd2, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkComb("lu_rt_unused", 5'b11000);
    bus.IFID_uses_rt = 1'b1;
    checkComb("lu_rt_comb", 5'b00010);
    tick();
    checkOutput("lu_rt_count", 32'(bus.stall_count), 32'd2);

    // Taken branch, no hazard
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkComb("br_comb", 5'b11100);
    tick();
    checkOutput("br_count", 32'(bus.stall_count), 32'd2);

    // Branch dependent on a load: bubble first, flush next cycle
    applyStimulus(1'b1, 4'd3, 4'd3, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkComb("br_lu_comb", 5'b00010);
    tick();
    bus.IDEX_MemRead = 1'b0;
    checkComb("br_after_lu_comb", 5'b11100);
    tick();
    checkOutput("br_lu_count", 32'(bus.stall_count), 32'd3);

    // Memory freeze over a load-use, then the single bubble
    applyStimulus(1'b1, 4'd9, 4'd9, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkComb($sformatf("freeze_%0d", i), 5'b00001);
      tick();
    end
    bus.mem_busy = 1'b0;
    checkComb("freeze_bubble", 5'b00010);
    tick();
    applyIdle();
    checkComb("freeze_done", 5'b11000);
    checkOutput("freeze_count", 32'(bus.stall_count), 32'd8);

    // Halt together with branch: halt wins, flush still asserted
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkComb("halt_comb", 5'b01100);
    tick();
    applyIdle();
    for (int i = 0; i < 3; i++) begin
      checkComb($sformatf("drain_comb_%0d", i), 5'b01110);
      checkOutput($sformatf("drain_halted_%0d", i), 32'(bus.halted), 32'd0);
      tick();
    end
    checkOutput("halted_edge4", 32'(bus.halted), 32'd1);
    checkComb("halted_comb", 5'b00001);
    checkOutput("halted_count", 32'(bus.stall_count), 32'd12);

    // Everything ignored once halted
    applyStimulus(1'b1, 4'd4, 4'd4, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    applyIdle();
    tick();
    checkOutput("halted_sticky", 32'(bus.halted), 32'd1);
    checkOutput("halted_count_frozen", 32'(bus.stall_count), 32'd12);
    checkComb("halted_comb_sticky", 5'b00001);

    // Halt with a 2-cycle memory freeze inside the drain
    doReset();
    checkOutput("rst2_halted", 32'(bus.halted), 32'd0);
    checkOutput("rst2_count", 32'(bus.stall_count), 32'd0);
    bus.halt_in = 1'b1;
    tick();
    bus.halt_in = 1'b0;
    tick();
    bus.mem_busy = 1'b1;
    checkComb("drain_freeze_comb", 5'b00001);
    tick();
    tick();
    bus.mem_busy = 1'b0;
    tick();
    checkOutput("drain_frz_edge5", 32'(bus.halted), 32'd0);
    tick();
    checkOutput("drain_frz_edge6", 32'(bus.halted), 32'd1);
    checkOutput("drain_frz_count", 32'(bus.stall_count), 32'd6);

    // Reset in the middle of a drain
    doReset();
    bus.halt_in = 1'b1;
    tick();
    bus.halt_in = 1'b0;
    tick();
    doReset();
    checkComb("mid_drain_rst_comb", 5'b11000);
    checkOutput("mid_drain_rst_count", 32'(bus.stall_count), 32'd0);
    tick();
    checkOutput("mid_drain_rst_halted", 32'(bus.halted), 32'd0);

    // Saturation of the stall counter
    bus.mem_busy = 1'b1;
    for (int i = 0; i < 65534; i++) tick();
    checkOutput("sat_pre", 32'(bus.stall_count), 32'd65534);
    tick();
    checkOutput("sat_max", 32'(bus.stall_count), 32'hFFFF);
    for (int i = 0; i < 4465; i++) tick();
    checkOutput("sat_nowrap", 32'(bus.stall_count), 32'hFFFF);
    bus.mem_busy = 1'b0;

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Central pipeline hazard and stall controller for the 5-stage core.
- Sits upstream of the per-stage control registers (EX/M/WB) and the IF/ID and ID/EX latches, and drives their stall, write-enable, flush and bubble controls.
- Handles load-use interlocks, taken-branch squash, memory-busy freeze and HLT drain.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- DRAIN_CYCLES, 3, cycles after HLT enters ID before `halted` asserts (EX, M, WB drain).
- CNT_W, 16, width of `stall_count`.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- IDEX_MemRead  in  1  instruction in EX is a load.
- IDEX_rd  in  4  destination register of instruction in EX.
- IFID_rs  in  4  source register 1 of instruction in ID.
- IFID_rt  in  4  source register 2 of instruction in ID.
- IFID_uses_rs  in  1  ID instruction reads rs.
- IFID_uses_rt  in  1  ID instruction reads rt.
- branch_taken  in  1  branch in ID resolved taken this cycle.
- halt_in  in  1  HLT decoded in ID.
- mem_busy  in  1  I- or D-memory not ready this cycle.
- pc_wen  out  1  PC write enable.
- ifid_wen  out  1  IF/ID latch write enable.
- ifid_flush  out  1  IF/ID latch loads a NOP next edge.
- idex_bubble  out  1  ID/EX control fields cleared next edge.
- stall_en  out  1  freeze for EX/M/WB registers (they use wen = ~stall_en).
- halted  out  1  pipeline drained after HLT.
- stall_count  out  CNT_W  cycles in which any stall or bubble was asserted.

Behaviour:
- Reset: rst_n low at a rising edge sets state=RUN, drain counter=0, halted=0, stall_count=0.
- Combinational outputs (pc_wen, ifid_wen, ifid_flush, idex_bubble, stall_en) are driven from state and current inputs with no added latency.
- While rst_n is low, combinational outputs follow the RUN rules.
- load_use = IDEX_MemRead & (IDEX_rd != 0) & ((IFID_uses_rs & IFID_rs == IDEX_rd) | (IFID_uses_rt & IFID_rt == IDEX_rd)). Register 0 never creates a hazard.
- States: RUN, DRAIN, HALTED.
- RUN default outputs: pc_wen=1, ifid_wen=1, ifid_flush=0, idex_bubble=0, stall_en=0.
- RUN priority, highest first:
  - (1) mem_busy: freeze all. pc_wen=0, ifid_wen=0, stall_en=1, no bubble, no flush. Branch, halt and load_use are ignored this cycle and re-evaluated next cycle.
  - (2) load_use: pc_wen=0, ifid_wen=0, idex_bubble=1, stall_en=0. Lasts exactly one cycle, because the load advances to M and load_use drops. A dependent branch waits; no flush that cycle.
  - (3) halt_in: pc_wen=0, ifid_flush=1, load drain counter with DRAIN_CYCLES, go to DRAIN.
  - (4) branch_taken: ifid_flush=1, pc_wen=1, stay in RUN.
- DRAIN outputs: pc_wen=0, ifid_wen=1, ifid_flush=1, idex_bubble=1, so only NOPs enter behind HLT.
- DRAIN counting:
  - If mem_busy, freeze as in RUN (1) and hold the counter.
  - Otherwise decrement the counter.
  - When the counter is 1 and decrements, go to HALTED next edge.
- HALTED outputs: pc_wen=0, ifid_wen=0, stall_en=1, ifid_flush=0, idex_bubble=0, halted=1. Only reset leaves HALTED; all inputs are ignored.
- stall_count increments by 1 on an edge where state != HALTED and (pc_wen==0 or stall_en==1 or idex_bubble==1). It saturates at all-ones, with no wrap.
- halted is registered and asserts on the edge that enters HALTED.
- Reset mid-DRAIN or mid-freeze returns to RUN on that same edge and clears all counters.
- Simultaneous halt_in and branch_taken: halt wins, and the flush still occurs.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with mem_busy=1 -> after release, state RUN, stall_count=0, halted=0. An asynchronous rst_n pulse between edges must have no effect.
- Load-use: IDEX_MemRead=1, IDEX_rd=5, IFID_rs=5, uses_rs=1 for one cycle -> pc_wen=0, ifid_wen=0, idex_bubble=1, stall_en=0 for 1 cycle; stall_count=1.
  - Repeat with IDEX_rd=0 -> no stall.
- Branch: branch_taken=1 with no hazard -> ifid_flush=1, pc_wen=1, stall_count unchanged.
  - With load_use also true -> bubble only, no flush; then flush on the next cycle when branch_taken=1.
- Memory freeze: mem_busy=1 for 4 cycles during load_use -> stall_en=1 for 4 cycles with no bubble; then a 1-cycle bubble; stall_count=5.
- Halt: halt_in=1 in RUN -> DRAIN for exactly 3 cycles, halted=1 on the 4th edge.
  - With mem_busy=1 for 2 cycles mid-DRAIN, halted is delayed to the 6th edge.
  - Afterwards, toggling all inputs leaves halted=1 and stall_count frozen.
- Saturation: force 70000 mem_busy cycles with CNT_W=16 -> stall_count=16'hFFFF, no wrap.
